instr_fetch_unit: RTL and testbench

Initiator side of the instruction-ROM interface. The block holds the PC and drives the ROM byte address. It tracks the ROM's one-cycle registered read latency and buffers fetched words in a small FIFO. It delivers {instruction, PC} pairs to decode over a valid/ready handshake and supports PC redirect for branches and jumps, with flush of stale fetches.

---
 rtl/instr_fetch_unit_pkg.sv | 19 +
 rtl/instr_fetch_unit_if.sv | 30 +++
 rtl/instr_fetch_unit_fifo.sv | 55 +++++
 rtl/instr_fetch_unit.sv | 109 ++++++++++
 tb/tb_instr_fetch_unit.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    localparam int          DEFAULT_WIDTH    = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'hFC00_0000;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] instr;
        logic [DEFAULT_WIDTH-1:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w_sum;
        w_sum = {1'b0, a} + {1'b0, b};
        return w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - ROM request/response and decode handshake bundle
interface instr_fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] ADDRESS;
    logic [WIDTH-1:0] INSTR;
    logic             DEC_VALID;
    logic             DEC_READY;
    logic [WIDTH-1:0] DEC_INSTR;
    logic [WIDTH-1:0] DEC_PC;

    modport master (
        output ADDRESS,
        input  INSTR,
        output DEC_VALID,
        input  DEC_READY,
        output DEC_INSTR,
        output DEC_PC
    );

    modport slave (
        input  ADDRESS,
        output INSTR,
        input  DEC_VALID,
        output DEC_READY,
        input  DEC_INSTR,
        input  DEC_PC
    );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// rtl/instr_fetch_unit_fifo.sv - fetch_skid_fifo: small power-of-two buffer of fetched {instr, pc}
module fetch_skid_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [CW-1:0] o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;

    assign w_pop = i_pop & (r_count != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is only observed while the count is nonzero.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC/ROM fetch initiator with redirect flush; FETCH_PERF_EN adds perf counters
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH      = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int               FIFO_DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             FETCH_EN,
    input  logic             REDIRECT_VALID,
    input  logic [WIDTH-1:0] REDIRECT_PC,
`ifdef FETCH_PERF_EN
    output logic [31:0]      PERF_FETCHED,
    output logic [31:0]      PERF_FLUSHED,
    output logic [31:0]      PERF_STALL,
`endif
    instr_fetch_unit_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = CW + 1;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_inflight_pc;
    logic             r_inflight_v;

    logic [CW-1:0]    w_count;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_entry;
    logic             w_dec_valid;
    logic             w_pop;
    logic             w_push;
    logic             w_issue;
    logic [OW-1:0]    w_occupancy;

    assign w_dec_valid = (w_count != '0);
    assign w_pop       = w_dec_valid & bus.DEC_READY;

    // Slots committed after this edge: buffered + landing word - departing head.
    assign w_occupancy = OW'(w_count) + OW'(r_inflight_v) - OW'(w_pop);
    assign w_issue     = FETCH_EN & ~REDIRECT_VALID & (w_occupancy < OW'(FIFO_DEPTH));
    assign w_push      = r_inflight_v & ~REDIRECT_VALID;

    assign w_push_entry.instr = bus.INSTR;
    assign w_push_entry.pc    = r_inflight_pc;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pc          <= RESET_PC;
            r_inflight_v  <= 1'b0;
            r_inflight_pc <= '0;
        end else if (REDIRECT_VALID) begin
            r_pc         <= {REDIRECT_PC[WIDTH-1:2], 2'b00};
            r_inflight_v <= 1'b0;
        end else if (w_issue) begin
            r_inflight_v  <= 1'b1;
            r_inflight_pc <= r_pc;
            r_pc          <= r_pc + WIDTH'(4);
        end else begin
            r_inflight_v <= 1'b0;
        end
    end

    fetch_skid_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (CLK),
        .i_rst_n     (RESET_N),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop & ~REDIRECT_VALID),
        .i_flush     (REDIRECT_VALID),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign bus.ADDRESS   = r_pc;
    assign bus.DEC_VALID = w_dec_valid;
    assign bus.DEC_INSTR = w_dec_valid ? w_head.instr : '0;
    assign bus.DEC_PC    = w_dec_valid ? w_head.pc    : '0;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushed;
    logic [31:0] r_perf_stall;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_push)
                r_perf_fetched <= sat_add32(r_perf_fetched, 32'd1);
            if (REDIRECT_VALID)
                r_perf_flushed <= sat_add32(r_perf_flushed, 32'(w_count) + 32'(r_inflight_v));
            if (w_dec_valid && !bus.DEC_READY)
                r_perf_stall <= sat_add32(r_perf_stall, 32'd1);
        end
    end

    assign PERF_FETCHED = r_perf_fetched;
    assign PERF_FLUSHED = r_perf_flushed;
    assign PERF_STALL   = r_perf_stall;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed and randomized checks of instr_fetch_unit against a stream model
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redir_v  = 1'b0;
    logic [31:0] redir_pc = '0;
    int          total    = 0;
    int          bad      = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.WIDTH(32)) bus1 ();
    instr_fetch_unit_if #(.WIDTH(32)) bus2 ();

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return 32'hA000_0000 | (addr >> 2);
    endfunction

    always @(posedge clk) begin
        bus1.INSTR <= rom_word(bus1.ADDRESS);
        bus2.INSTR <= rom_word(bus2.ADDRESS);
    end
    assign bus2.DEC_READY = 1'b1;

`ifdef FETCH_PERF_EN
    logic [31:0] p1_fetched, p1_flushed, p1_stall;
    logic [31:0] p2_fetched, p2_flushed, p2_stall;
`endif

    instr_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) u_dut (
        .CLK            (clk),
        .RESET_N        (rst_n),
        .FETCH_EN       (fetch_en),
        .REDIRECT_VALID (redir_v),
        .REDIRECT_PC    (redir_pc),
`ifdef FETCH_PERF_EN
        .PERF_FETCHED   (p1_fetched),
        .PERF_FLUSHED   (p1_flushed),
        .PERF_STALL     (p1_stall),
`endif
        .bus            (bus1)
    );

    instr_fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_dut_wrap (
        .CLK            (clk),
        .RESET_N        (rst_n),
        .FETCH_EN       (fetch_en),
        .REDIRECT_VALID (1'b0),
        .REDIRECT_PC    (32'h0),
`ifdef FETCH_PERF_EN
        .PERF_FETCHED   (p2_fetched),
        .PERF_FLUSHED   (p2_flushed),
        .PERF_STALL     (p2_stall),
`endif
        .bus            (bus2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0, the first cycle out of reset.
    task automatic do_reset();
        rst_n          = 1'b0;
        redir_v        = 1'b0;
        fetch_en       = 1'b1;
        bus1.DEC_READY = 1'b1;
        next_cycle();
        @(negedge clk);
        check_eq("rst_valid", 32'(bus1.DEC_VALID), 32'h0);
        check_eq("rst_instr", bus1.DEC_INSTR, 32'h0);
        check_eq("rst_pc", bus1.DEC_PC, 32'h0);
        check_eq("rst_addr", bus1.ADDRESS, 32'h0);
        check_eq("rst_addr_wrap", bus2.ADDRESS, 32'hFFFF_FFF8);
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] hold_pc, hold_instr;
        logic        prev_hold;
        int          pops;
`ifdef FETCH_PERF_EN
        logic [31:0] snap;
`endif
        #2;

        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("t1_addr", bus1.ADDRESS, 32'(4 * k));
            check_eq("t1_valid", 32'(bus1.DEC_VALID), (k >= 2) ? 32'h1 : 32'h0);
            if (k >= 2) begin
                check_eq("t1_pc", bus1.DEC_PC, 32'(4 * (k - 2)));
                check_eq("t1_instr", bus1.DEC_INSTR, rom_word(32'(4 * (k - 2))));
                check_eq("t5_wrap_pc", bus2.DEC_PC, 32'hFFFF_FFF8 + 32'(4 * (k - 2)));
            end else begin
                check_eq("t5_wrap_valid", 32'(bus2.DEC_VALID), 32'h0);
            end
            next_cycle();
        end

        do_reset();
        for (int k = 0; k < 13; k++) begin
            bus1.DEC_READY = !(k >= 2 && k <= 6);
            @(negedge clk);
`ifdef FETCH_PERF_EN
            if (k == 2) snap = p1_stall;
            if (k == 7) check_eq("perf_stall", p1_stall - snap, 32'd5);
`endif
            if (k >= 2 && k <= 6) begin
                check_eq("t2_hold_valid", 32'(bus1.DEC_VALID), 32'h1);
                check_eq("t2_hold_pc", bus1.DEC_PC, 32'h0);
                check_eq("t2_hold_instr", bus1.DEC_INSTR, 32'hA000_0000);
                check_eq("t2_hold_addr", bus1.ADDRESS, 32'h8);
            end else if (k >= 7) begin
                check_eq("t2_resume_valid", 32'(bus1.DEC_VALID), 32'h1);
                check_eq("t2_resume_pc", bus1.DEC_PC, 32'(4 * (k - 7)));
                check_eq("t2_resume_instr", bus1.DEC_INSTR, rom_word(32'(4 * (k - 7))));
            end
            next_cycle();
        end

        do_reset();
        for (int k = 0; k < 11; k++) begin
            redir_v  = (k == 6);
            redir_pc = 32'h26;
            @(negedge clk);
`ifdef FETCH_PERF_EN
            if (k == 6) snap = p1_flushed;
            if (k == 7) check_eq("perf_flushed", p1_flushed - snap, 32'd2);
`endif
            if (k == 7) check_eq("t3_addr", bus1.ADDRESS, 32'h24);
            if (k == 7 || k == 8) check_eq("t3_gap_valid", 32'(bus1.DEC_VALID), 32'h0);
            if (k == 9) begin
                check_eq("t3_valid", 32'(bus1.DEC_VALID), 32'h1);
                check_eq("t3_pc", bus1.DEC_PC, 32'h24);
                check_eq("t3_instr", bus1.DEC_INSTR, 32'hA000_0009);
            end
            next_cycle();
        end
        redir_v = 1'b0;

        do_reset();
        for (int k = 0; k < 12; k++) begin
            redir_v  = (k == 6 || k == 7);
            redir_pc = (k == 6) ? 32'h40 : 32'h80;
            @(negedge clk);
            if (k == 8) check_eq("t4_addr", bus1.ADDRESS, 32'h80);
            if (k == 8 || k == 9) check_eq("t4_gap_valid", 32'(bus1.DEC_VALID), 32'h0);
            if (k == 10) begin
                check_eq("t4_valid", 32'(bus1.DEC_VALID), 32'h1);
                check_eq("t4_pc", bus1.DEC_PC, 32'h80);
                check_eq("t4_instr", bus1.DEC_INSTR, rom_word(32'h80));
            end
            next_cycle();
        end
        redir_v = 1'b0;

        rst_n = 1'b0;
        #2;
        check_eq("mid_rst_valid", 32'(bus1.DEC_VALID), 32'h0);
        check_eq("mid_rst_pc", bus1.DEC_PC, 32'h0);
        check_eq("mid_rst_instr", bus1.DEC_INSTR, 32'h0);
        check_eq("mid_rst_addr", bus1.ADDRESS, 32'h0);

        // Stream model: every accepted word continues the current path from its start or redirect target.
        do_reset();
        exp_pc    = 32'h0;
        prev_hold = 1'b0;
        hold_pc   = '0;
        hold_instr = '0;
        pops      = 0;
        for (int k = 0; k < 3000; k++) begin
            if (k < 2990) begin
                fetch_en       = ($urandom_range(0, 9) < 8);
                bus1.DEC_READY = ($urandom_range(0, 9) < 7);
                redir_v        = ($urandom_range(0, 19) == 0);
                redir_pc       = $urandom;
            end else begin
                fetch_en       = 1'b1;
                bus1.DEC_READY = 1'b1;
                redir_v        = 1'b0;
            end
            @(negedge clk);
            if (prev_hold) begin
                check_eq("rnd_hold_valid", 32'(bus1.DEC_VALID), 32'h1);
                check_eq("rnd_hold_pc", bus1.DEC_PC, hold_pc);
                check_eq("rnd_hold_instr", bus1.DEC_INSTR, hold_instr);
            end
            if (bus1.DEC_VALID && bus1.DEC_READY && !redir_v) begin
                check_eq("rnd_pc", bus1.DEC_PC, exp_pc);
                check_eq("rnd_instr", bus1.DEC_INSTR, rom_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (redir_v) exp_pc = {redir_pc[31:2], 2'b00};
            prev_hold  = bus1.DEC_VALID && !bus1.DEC_READY && !redir_v;
            hold_pc    = bus1.DEC_PC;
            hold_instr = bus1.DEC_INSTR;
            if (k == 2999) check_eq("rnd_drain_valid", 32'(bus1.DEC_VALID), 32'h1);
            next_cycle();
        end
        check_eq("rnd_progress", 32'(pops >= 300), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
